// File: rtl/max31855_spi_responder.sv
// MAX31855-style thermocouple converter, device side of the SPI link.
// A free-running conversion timer snapshots temperatures and fault flags into
// result_q. Each chip-select frame shifts that snapshot out MSB-first on MISO.
// spi_cs_n and spi_sck are asynchronous. Each one passes through a
// three-flop chain: two flops to synchronize and a third for edge detection.
module max31855_spi_responder #(
    parameter int CONV_CYCLES = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] tc_temp_in,
    input  logic [11:0] junction_temp_in,
    input  logic        fault_oc,
    input  logic        fault_scg,
    input  logic        fault_scv,
    input  logic        spi_cs_n,
    input  logic        spi_sck,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        result_valid,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CW = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);

    // [0] first sync flop, [1] synchronized value, [2] delayed copy for edges
    logic [2:0]    cs_sync_q, cs_sync_d;
    logic [2:0]    sck_sync_q, sck_sync_d;
    logic [CW-1:0] conv_cnt_q, conv_cnt_d;
    logic [31:0]   result_q, result_d;
    logic [31:0]   shift_q, shift_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    state_t        state_q, state_d;
    logic          valid_q, valid_d;
    logic          miso_q, miso_d;
    logic          oe_q, oe_d;
    logic          frame_done_q, frame_done_d;

    logic        cs_fall, cs_rise, sck_rise, sck_fall;
    logic [31:0] frame_in;

    assign cs_fall  = ~cs_sync_q[1] &  cs_sync_q[2];
    assign cs_rise  =  cs_sync_q[1] & ~cs_sync_q[2];
    assign sck_rise =  sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] &  sck_sync_q[2];

    assign frame_in = {tc_temp_in, 1'b0, fault_oc | fault_scg | fault_scv,
                       junction_temp_in, 1'b0, fault_scv, fault_scg, fault_oc};

    assign spi_miso     = miso_q;
    assign spi_miso_oe  = oe_q;
    assign result_valid = valid_q;
    assign frame_done   = frame_done_q;

    // Next-state logic: synchronizers, conversion timer, frame FSM, registered outputs
    always_comb begin
        cs_sync_d    = {cs_sync_q[1:0], spi_cs_n};
        sck_sync_d   = {sck_sync_q[1:0], spi_sck};
        conv_cnt_d   = conv_cnt_q;
        result_d     = result_q;
        valid_d      = valid_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        state_d      = state_q;
        frame_done_d = 1'b0;

        // The timer is gated on the delayed CS copy, so a terminal count in the
        // same cycle as a CS fall still captures. The frame being loaded in that
        // cycle takes the old result_q. The new snapshot goes out in the next frame.
        if (cs_sync_q[2]) begin
            if (conv_cnt_q == CONV_LAST) begin
                conv_cnt_d = '0;
                result_d   = frame_in;
                valid_d    = 1'b1;
            end else begin
                conv_cnt_d = conv_cnt_q + 1'b1;
            end
        end else begin
            conv_cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    shift_d   = result_q;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sck_fall) begin
                    shift_d = {shift_q[30:0], 1'b0};
                end else if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd31) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (cs_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so MISO and oe land on E+2.
        oe_d   = (state_d != IDLE);
        miso_d = (state_d == SHIFT) ? shift_d[31] : 1'b0;
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q    <= 3'b111;
            sck_sync_q   <= 3'b000;
            conv_cnt_q   <= '0;
            result_q     <= '0;
            valid_q      <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            state_q      <= IDLE;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cs_sync_q    <= cs_sync_d;
            sck_sync_q   <= sck_sync_d;
            conv_cnt_q   <= conv_cnt_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            state_q      <= state_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_max31855_spi_responder.sv
// Directed bench for max31855_spi_responder.
// It acts as an SPI controller and keeps a queue of expected frames.
module tb_max31855_spi_responder;

    localparam int CONV = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] tc_temp_in = '0;
    logic [11:0] junction_temp_in = '0;
    logic        fault_oc = 1'b0, fault_scg = 1'b0, fault_scv = 1'b0;
    logic        spi_cs_n = 1'b1, spi_sck = 1'b0;
    logic        spi_miso, spi_miso_oe, result_valid, frame_done;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    logic [63:0] exp_q[$];

    max31855_spi_responder #(.CONV_CYCLES(CONV)) dut (
        .clk(clk), .rst(rst), .tc_temp_in(tc_temp_in), .junction_temp_in(junction_temp_in),
        .fault_oc(fault_oc), .fault_scg(fault_scg), .fault_scv(fault_scv),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_miso(spi_miso),
        .spi_miso_oe(spi_miso_oe), .result_valid(result_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Count the clock cycles in which frame_done is high
    always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    function automatic logic [31:0] mk_frame(input logic [13:0] tc, input logic [11:0] j,
                                             input logic oc, input logic scg, input logic scv);
        logic [31:0] f;
        f = '0;
        f[31:18] = tc;
        f[16]    = oc | scg | scv;
        f[15:4]  = j;
        f[2]     = scv;
        f[1]     = scg;
        f[0]     = oc;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sample MISO just before each SCK rise, which is where the controller latches it
    task automatic clock_bits(input int n, output logic [63:0] d);
        d = '0;
        for (int i = 0; i < n; i++) begin
            d = {d[62:0], spi_miso};
            spi_sck = 1'b1;
            cyc(4);
            spi_sck = 1'b0;
            cyc(4);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        spi_cs_n = 1'b0;
        cyc(6);
    endtask

    task automatic end_frame();
        cyc(4);
        spi_cs_n = 1'b1;
        cyc(6);
    endtask

    // Run one frame of n bits and check it against the head of the expected queue
    task automatic read_check(input string tag, input int n);
        logic [63:0] d;
        logic [63:0] e;
        int fd0;
        fd0 = fd_cnt;
        start_frame();
        clock_bits(n, d);
        end_frame();
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, d, e);
        end
        chk({tag, "_fd"}, 64'(fd_cnt - fd0), 64'd1);
    endtask

    initial begin
        logic [63:0] d;
        int fd0;
        logic [31:0] nom, flt, neg;
        nom = mk_frame(14'h0320, 12'h190, 1'b0, 1'b0, 1'b0);
        flt = mk_frame(14'h0320, 12'h190, 1'b1, 1'b0, 1'b0);
        neg = mk_frame(14'h3FD8, 12'h000, 1'b0, 1'b0, 1'b0);

        // Reset state
        cyc(4);
        chk("rst_miso", 64'(spi_miso), 64'd0);
        chk("rst_oe", 64'(spi_miso_oe), 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_fd", 64'(frame_done), 64'd0);
        rst = 1'b0;

        // Early read: no conversion has completed yet
        exp_q.push_back(64'd0);
        read_check("early", 32);
        chk("early_valid", 64'(result_valid), 64'd0);

        // Nominal frame
        tc_temp_in = 14'h0320;
        junction_temp_in = 12'h190;
        cyc(CONV + 10);
        chk("nom_valid", 64'(result_valid), 64'd1);
        exp_q.push_back(64'(nom));
        read_check("nominal", 32);

        // Open-circuit fault
        fault_oc = 1'b1;
        cyc(CONV + 10);
        exp_q.push_back(64'(flt));
        read_check("fault", 32);

        // Negative thermocouple temperature
        fault_oc = 1'b0;
        tc_temp_in = 14'h3FD8;
        junction_temp_in = 12'h000;
        cyc(CONV + 10);
        exp_q.push_back(64'(neg));
        read_check("negative", 32);

        // Abort after 10 bits: no frame_done, and oe drops by E+2
        fd0 = fd_cnt;
        exp_q.push_back(64'(neg >> 22));
        start_frame();
        clock_bits(10, d);
        @(negedge clk);
        spi_cs_n = 1'b1;
        cyc(3);
        chk("abort_oe", 64'(spi_miso_oe), 64'd0);
        chk("abort_bits", d, exp_q.pop_front());
        chk("abort_fd", 64'(fd_cnt - fd0), 64'd0);
        cyc(6);
        exp_q.push_back(64'(neg));
        read_check("after_abort", 32);

        // Conversion hold: inputs change while CS is low for 3 periods
        @(negedge clk);
        spi_cs_n = 1'b0;
        cyc(6);
        tc_temp_in = 14'h0320;
        junction_temp_in = 12'h190;
        cyc(3 * CONV);
        spi_cs_n = 1'b1;
        cyc(10);
        exp_q.push_back(64'(neg));
        read_check("hold_old", 32);
        cyc(CONV + 10);
        exp_q.push_back(64'(nom));
        read_check("hold_new", 32);

        // Overclock: 40 pulses, and bits 33-40 read 0
        exp_q.push_back({24'd0, nom, 8'h00});
        read_check("overclock", 40);

        // Reset at bit 16 of a frame
        start_frame();
        clock_bits(16, d);
        rst = 1'b1;
        cyc(1);
        chk("midrst_miso", 64'(spi_miso), 64'd0);
        chk("midrst_oe", 64'(spi_miso_oe), 64'd0);
        chk("midrst_valid", 64'(result_valid), 64'd0);
        spi_cs_n = 1'b1;
        cyc(4);
        rst = 1'b0;
        cyc(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/max31855_spi_responder.md
# max31855_spi_responder

SPI responder model of a MAX31855-style thermocouple-to-digital converter, the device end of the thermocouple SPI link. It periodically captures thermocouple temperature, cold-junction temperature and fault flags into a result register, then shifts the 32-bit frame MSB-first on MISO when the controller asserts chip select. It sits in the testbench/emulation layer, opposite the thermocouple controller FSM, and drives that controller's SPI receive path.

## Interface
- CONV_CYCLES, default 400: clk cycles per conversion period; minimum 2.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tc_temp_in  input  14  thermocouple temperature, two's complement, 0.25 °C/LSB.
- junction_temp_in  input  12  cold-junction temperature, two's complement, 0.0625 °C/LSB.
- fault_oc  input  1  open-circuit fault.
- fault_scg  input  1  short-to-GND fault.
- fault_scv  input  1  short-to-VCC fault.
- spi_cs_n  input  1  chip select, active low, asynchronous to clk.
- spi_sck  input  1  SPI clock (CPOL=0), asynchronous to clk.
- spi_miso  output  1  serial data out.
- spi_miso_oe  output  1  high while a frame is selected (CS low, synchronized).
- result_valid  output  1  high once the first conversion has completed since reset.
- frame_done  output  1  one-cycle pulse on the 32nd SCK rising edge of a frame.

## Operation
- Synchronizers: spi_cs_n and spi_sck each pass through two flops, plus a third flop for edge detection. CS fall = cs_s2 low & cs_s3 high; SCK rise/fall are defined the same way. Synchronizer flops reset to cs=1, sck=0.
- Frame format, frame[31:0]: [31:18] tc_temp_in; [17] 0; [16] fault_oc|fault_scg|fault_scv; [15:4] junction_temp_in; [3] 0; [2] fault_scv; [1] fault_scg; [0] fault_oc.
- Conversion: conv_cnt runs only while synchronized CS is high. At conv_cnt == CONV_CYCLES-1:
  - capture the frame from the inputs into result_reg;
  - set result_valid;
  - clear conv_cnt to 0.
- While CS is low, conv_cnt is held at 0 and the conversion is aborted. The next period restarts from 0 after CS rises.
- States: IDLE, SHIFT, DONE.
  - IDLE: spi_miso_oe=0, spi_miso=0. On CS fall: shift_reg <= result_reg, bit_cnt <= 0, go to SHIFT.
  - SHIFT: spi_miso = shift_reg[31].
    - SCK fall: shift_reg shifts left, filling with 0.
    - SCK rise: bit_cnt increments.
    - When bit_cnt reaches 32 (on the 32nd rise): pulse frame_done, go to DONE.
  - DONE: spi_miso=0, spi_miso_oe=1. Further SCK edges are ignored.
- CS rise in SHIFT or DONE: return to IDLE. An aborted frame emits no frame_done.
- Simultaneous events:
  - CS fall and SCK edge detected in the same cycle: the load wins, and the SCK edge is ignored.
  - Conversion terminal count in the same cycle as CS fall: the capture still occurs. The frame loads the previous result_reg, and the new capture appears in the next frame.
- SCK edges while CS is high are ignored.
- Before the first conversion, result_reg = 0, so an early frame reads all zeros.
- rst mid-frame: returns immediately to reset state. MISO goes to 0 and oe to 0 on the next cycle.

## Timing
- Reset values:
  - spi_miso=0, spi_miso_oe=0, result_valid=0, frame_done=0;
  - result_reg=0, shift_reg=0, conv_cnt=0, bit_cnt=0;
  - state IDLE.
- Input sampled low at edge E:
  - edge detected combinationally after E+1;
  - registered action (MISO/oe update) at edge E+2.
- SCK high and low times must each be ≥3 clk cycles. CS setup to first SCK rise must be ≥3 clk cycles.
- MISO changes only on synchronized SCK fall or CS fall. Bit 31 is valid before the first SCK rise.
- Capture into result_reg happens exactly CONV_CYCLES cycles after CS high is synchronized, repeating while CS stays high.
- frame_done is asserted for exactly one cycle, registered at E+2 of the 32nd SCK rise.

## Test plan
- Nominal frame:
  - Stimulus: tc=14'h0320 (200 °C), junction=12'h190 (25 °C), no faults; wait >CONV_CYCLES; clock 32 bits.
  - Required: controller reads 32'h0C801900 and frame_done pulses once.
- Fault:
  - Stimulus: fault_oc=1 with the same temperatures.
  - Required: frame reads 32'h0C811901.
- Negative temperature:
  - Stimulus: tc=14'h3FD8 (−10 °C), junction=0.
  - Required: frame reads 32'hFF600000.
- Early read and abort:
  - Stimulus 1: CS low immediately after reset.
  - Required 1: frame reads 0 and result_valid=0.
  - Stimulus 2: CS rise after 10 bits.
  - Required 2: no frame_done, oe=0 within 2 cycles, next frame complete and correct.
- Conversion hold:
  - Stimulus: change inputs while CS is held low for 3×CONV_CYCLES.
  - Required: the next frame still shows the old values. New values appear only after CS has been high for CONV_CYCLES.
- Overclock and reset:
  - Stimulus 1: 40 SCK pulses in one frame.
  - Required 1: bits 33–40 read 0.
  - Stimulus 2: rst at bit 16.
  - Required 2: MISO=0, oe=0, result_valid=0 on the following cycle.
